// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - RV32I/M execute unit: single-cycle base ALU plus iterative multiply/divide
//
// Purpose: accepts one decoded RV32I/M operation per handshake and returns one
// registered result. Base ALU ops finish one cycle after acceptance. Multiply and
// divide iterate one bit per enabled cycle over a 2*XLEN accumulator.
//
// Ports:
//   clk, rst (async active-low), clk_en (global hold when low)
//   i_valid / o_ready           : request handshake
//   i_opcode, i_funct7, i_funct3: decode fields
//   i_rs1_data, i_rs2_data      : XLEN-bit operands
//   i_imm                       : 32-bit sign-extended immediate
//   o_valid / i_ready           : result handshake
//   o_rd_data                   : registered result
//   o_busy                      : high while a multiply/divide iterates
module alu_mdu #(
    parameter int DATA_WIDTH    = 31,
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [6:0]            i_opcode,
    input  logic [6:0]            i_funct7,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH:0]   i_rs1_data,
    input  logic [DATA_WIDTH:0]   i_rs2_data,
    input  logic [31:0]           i_imm,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH:0]   o_rd_data,
    output logic                  o_busy
);
    localparam int XLEN = DATA_WIDTH + 1;
    localparam int SW   = $clog2(XLEN);
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic              neg;
    logic [2:0]        op_f3;

    // Decode and single-cycle results
    logic            is_r, is_i, is_m, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
    logic            div_zero, div_ovf, quick, neg_load;
    logic [XLEN-1:0] imm_x, op_b, alu_res, quick_res, mag_a, mag_b;
    logic [SW-1:0]   shamt;

    always_comb begin
        is_r       = (i_opcode == 7'b0110011);
        is_i       = (i_opcode == 7'b0010011);
        is_m       = is_r && (i_funct7 == 7'b0000001);
        imm_x      = XLEN'($signed(i_imm));
        op_b       = is_r ? i_rs2_data : imm_x;
        shamt      = op_b[SW-1:0];
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU keeps rs2 unsigned
        rs1_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                     (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
        rs2_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
        rs1_neg    = rs1_signed && i_rs1_data[XLEN-1];
        rs2_neg    = rs2_signed && i_rs2_data[XLEN-1];
        mag_a      = rs1_neg ? -i_rs1_data : i_rs1_data;
        mag_b      = rs2_neg ? -i_rs2_data : i_rs2_data;
        div_zero   = (i_rs2_data == '0);
        div_ovf    = !i_funct3[0] && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (i_rs2_data == '1);
        quick      = i_funct3[2] && (div_ovf || (div_zero && DIV_ZERO_FAST));
        if (div_ovf)
            quick_res = i_funct3[1] ? '0 : i_rs1_data;
        else
            quick_res = i_funct3[1] ? i_rs1_data : '1;
        // Quotient sign is dropped for divide-by-zero so the iterated all-ones
        // magnitude comes out unchanged; the remainder keeps rs1's sign.
        if (i_funct3[2] && i_funct3[1])
            neg_load = rs1_neg;
        else if (i_funct3[2])
            neg_load = (rs1_neg ^ rs2_neg) && !div_zero;
        else
            neg_load = rs1_neg ^ rs2_neg;

        alu_res = '0;
        if (is_r || is_i) begin
            case (i_funct3)
                3'b000: alu_res = (is_r && i_funct7 == 7'b0100000) ? i_rs1_data - op_b
                                                                    : i_rs1_data + op_b;
                3'b001: alu_res = i_rs1_data << shamt;
                3'b010: alu_res = XLEN'($signed(i_rs1_data) < $signed(op_b));
                3'b011: alu_res = XLEN'(i_rs1_data < op_b);
                3'b100: alu_res = i_rs1_data ^ op_b;
                3'b101: begin
                    if (is_r ? (i_funct7 == 7'b0100000) : (i_imm[11:5] == 7'b0100000))
                        alu_res = $signed(i_rs1_data) >>> shamt;
                    else
                        alu_res = i_rs1_data >> shamt;
                end
                3'b110: alu_res = i_rs1_data | op_b;
                default: alu_res = i_rs1_data & op_b;
            endcase
        end
    end

    // One iteration step and the signed result produced on the last step
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   div_val, fin_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        // Restoring divide: trial-subtract from the left-shifted partial remainder
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
        if (state == MUL)
            acc_step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_step = {acc[2*XLEN-2:0], 1'b0};
        else
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

        prod    = neg ? -acc_step : acc_step;
        div_val = op_f3[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (state == MUL)
            fin_res = (op_f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            fin_res = neg ? -div_val : div_val;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (is_m && !quick)
                        state_next = i_funct3[2] ? DIV : MUL;
                    else
                        state_next = DONE;
                end
            end
            MUL, DIV: if (cnt == CW'(1)) state_next = DONE;
            default:  if (i_ready) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (clk_en)
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            acc       <= '0;
            opb       <= '0;
            neg       <= 1'b0;
            op_f3     <= '0;
            o_rd_data <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_f3 <= i_funct3;
                        if (is_m && !quick) begin
                            acc <= {{XLEN{1'b0}}, mag_a};
                            opb <= mag_b;
                            neg <= neg_load;
                            cnt <= CW'(XLEN);
                        end else begin
                            o_rd_data <= is_m ? quick_res : alu_res;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        o_rd_data <= fin_res;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = rst && (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state == MUL) || (state == DIV);
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed and randomized checks of alu_mdu against an arithmetic model
module tb_alu_mdu;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] F7_M = 7'b0000001;
    localparam logic [6:0] F7_A = 7'b0100000;

    logic        clk = 1'b0;
    logic        rst, clk_en, i_valid, i_ready, o_ready, o_valid, o_busy;
    logic [6:0]  i_opcode, i_funct7;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data, i_rs2_data, i_imm, o_rd_data;

    int checks = 0;
    int errors = 0;

    alu_mdu #(.DATA_WIDTH(31), .DIV_ZERO_FAST(1'b1)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct7(i_funct7), .i_funct3(i_funct3),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .o_valid(o_valid), .i_ready(i_ready), .o_rd_data(o_rd_data), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [6:0] opc, input logic [6:0] f7,
                                          input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        int sa, sb, so;
        longint ps;
        longint unsigned pu;
        logic [31:0] op2;
        logic [4:0] sh;
        sa = a;
        sb = b;
        if (opc == OP_R && f7 == F7_M) begin
            pu = {32'b0, a} * {32'b0, b};
            case (f3)
                3'd0: return pu[31:0];
                3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
                3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
                3'd3: return pu[63:32];
                3'd4: begin
                    if (b == 0) return 32'hFFFFFFFF;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                    return sa / sb;
                end
                3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
                3'd6: begin
                    if (b == 0) return a;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                    return sa % sb;
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        if (opc != OP_R && opc != OP_I) return 0;
        op2 = (opc == OP_R) ? b : imm;
        sh = op2[4:0];
        case (f3)
            3'd0: return (opc == OP_R && f7 == F7_A) ? a - op2 : a + op2;
            3'd1: return a << sh;
            3'd2: return (sa < int'(op2)) ? 1 : 0;
            3'd3: return (a < op2) ? 1 : 0;
            3'd4: return a ^ op2;
            3'd5: begin
                if ((opc == OP_R) ? (f7 == F7_A) : (imm[11:5] == F7_A)) begin
                    so = sa >>> sh;
                    return so;
                end
                return a >> sh;
            end
            3'd6: return a | op2;
            default: return a & op2;
        endcase
    endfunction

    function automatic int model_lat(input logic [6:0] opc, input logic [6:0] f7,
                                     input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (opc != OP_R || f7 != F7_M) return 1;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return $urandom_range(0, 20);
            5: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input int hold, input int freeze_at, input string tag);
        logic [31:0] exp;
        int lat, frz, cyc, busy_n;
        exp = model(opc, f7, f3, a, b, imm);
        lat = model_lat(opc, f7, f3, a, b);
        frz = (freeze_at > 0) ? 10 : 0;
        @(negedge clk);
        check({tag, ".ready"}, 32'(o_ready), 32'd1);
        i_opcode = opc; i_funct7 = f7; i_funct3 = f3;
        i_rs1_data = a; i_rs2_data = b; i_imm = imm;
        i_valid = 1'b1; i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        i_opcode = 7'($urandom); i_funct7 = 7'($urandom); i_funct3 = 3'($urandom);
        i_rs1_data = $urandom; i_rs2_data = $urandom; i_imm = $urandom;
        cyc = 1;
        busy_n = 0;
        while (!o_valid && cyc < 200) begin
            if (o_busy) busy_n++;
            @(negedge clk);
            cyc++;
            if (freeze_at > 0 && cyc == freeze_at) clk_en = 1'b0;
            if (freeze_at > 0 && cyc == freeze_at + 10) clk_en = 1'b1;
        end
        clk_en = 1'b1;
        check({tag, ".latency"}, 32'(cyc), 32'(lat + frz));
        check({tag, ".busy_cycles"}, 32'(busy_n), (lat > 1) ? 32'(lat - 1 + frz) : 32'd0);
        check({tag, ".result"}, o_rd_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
            check({tag, ".hold_data"}, o_rd_data, exp);
        end
        // Release the result while offering a new base op: it must not be taken in this edge
        i_ready = 1'b1;
        i_valid = 1'b1; i_opcode = OP_R; i_funct7 = 7'd0; i_funct3 = 3'd0;
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        check({tag, ".released_valid"}, 32'(o_valid), 32'd0);
        check({tag, ".released_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        int seen;
        logic [6:0] ropc, rf7;
        logic [2:0] rf3;
        rst = 1'b0; clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_opcode = '0; i_funct7 = '0; i_funct3 = '0;
        i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
        repeat (3) @(negedge clk);
        check("reset.ready", 32'(o_ready), 32'd0);
        check("reset.valid", 32'(o_valid), 32'd0);
        check("reset.busy", 32'(o_busy), 32'd0);
        check("reset.data", o_rd_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset.ready_after", 32'(o_ready), 32'd1);

        run_op(OP_R, 7'd0, 3'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 0, 0, "add_ovf");
        run_op(OP_R, F7_M, 3'd1, 32'h80000000, 32'h80000000, 32'd0, 0, 0, "mulh_min");
        run_op(OP_R, F7_M, 3'd0, 32'h80000000, 32'h80000000, 32'd0, 0, 0, "mul_min");
        run_op(OP_R, F7_M, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, "div_ovf");
        run_op(OP_R, F7_M, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, "rem_ovf");
        run_op(OP_R, F7_M, 3'd5, 32'd7, 32'd0, 32'd0, 0, 0, "divu_zero");
        run_op(OP_R, F7_M, 3'd7, 32'd7, 32'd0, 32'd0, 0, 0, "remu_zero");
        run_op(OP_R, F7_M, 3'd4, -32'sd5, 32'd0, 32'd0, 0, 0, "div_zero_neg");
        run_op(OP_R, F7_M, 3'd6, -32'sd5, 32'd0, 32'd0, 0, 0, "rem_zero_neg");
        run_op(OP_R, F7_M, 3'd6, -32'sd7, 32'd2, 32'd0, 5, 0, "rem_neg");
        run_op(OP_R, F7_M, 3'd4, -32'sd7, 32'd2, 32'd0, 0, 0, "div_neg");
        run_op(OP_R, F7_M, 3'd5, 32'd1000, 32'd7, 32'd0, 0, 5, "divu_freeze");
        run_op(OP_R, F7_M, 3'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 0, 0, "mulhsu");
        run_op(OP_R, F7_A, 3'd0, 32'd3, 32'd5, 32'd0, 0, 0, "sub");
        run_op(OP_R, F7_A, 3'd5, 32'h80000000, 32'd36, 32'd0, 0, 0, "sra");
        run_op(OP_I, 7'd0, 3'd5, 32'h80000010, 32'd0, 32'h00000404, 0, 0, "srai");
        run_op(OP_I, 7'd0, 3'd3, 32'd5, 32'd0, 32'hFFFFFFF0, 0, 0, "sltiu");
        run_op(OP_I, 7'd0, 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFC, 0, 0, "slti");
        run_op(7'b0000011, 7'd0, 3'd0, 32'd9, 32'd9, 32'd9, 0, 0, "unsupported");

        // Reset during MULHU iteration discards the operation
        @(negedge clk);
        i_opcode = OP_R; i_funct7 = F7_M; i_funct3 = 3'd3;
        i_rs1_data = 32'hDEADBEEF; i_rs2_data = 32'h12345678; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid.busy", 32'(o_busy), 32'd0);
        check("rst_mid.valid", 32'(o_valid), 32'd0);
        check("rst_mid.data", o_rd_data, 32'd0);
        check("rst_mid.ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("rst_mid.no_valid", 32'(seen), 32'd0);
        run_op(OP_I, 7'd0, 3'd0, 32'd10, 32'd0, 32'hFFFFFFFF, 0, 0, "addi_after_rst");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ropc = OP_R;
                    rf7 = ($urandom_range(0, 1) != 0) ? F7_A : 7'd0;
                end
                1: begin ropc = OP_I; rf7 = 7'($urandom); end
                2: begin ropc = OP_R; rf7 = F7_M; end
                default: begin ropc = 7'($urandom); rf7 = 7'($urandom); end
            endcase
            rf3 = 3'($urandom);
            run_op(ropc, rf7, rf3, rnd_val(), rnd_val(),
                   ($urandom_range(0, 3) == 0) ? {20'h0, 12'h400 | 12'($urandom_range(0, 31))}
                                               : 32'($signed(12'($urandom))),
                   $urandom_range(0, 3), 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 31, meaning the MSB index of data ports (XLEN = DATA_WIDTH+1).
REQ-002 The block SHALL have parameter DIV_ZERO_FAST, default 1, meaning divide-by-zero completes without iterating.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clk_en  input  1  when low, all registered state holds.
REQ-006 The block SHALL have port i_valid  input  1  operation request.
REQ-007 The block SHALL have port o_ready  output  1  block can accept a request.
REQ-008 The block SHALL have ports i_opcode  input  7, i_funct7  input  7, i_funct3  input  3  RV32I/M decode fields.
REQ-009 The block SHALL have ports i_rs1_data, i_rs2_data  input  XLEN  operands, and i_imm  input  32  sign-extended immediate.
REQ-010 The block SHALL have port o_valid  output  1  result available.
REQ-011 The block SHALL have port i_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port o_rd_data  output  XLEN  registered result.
REQ-013 The block SHALL have port o_busy  output  1  high while an M-extension op iterates.

Function
REQ-014 Request accepted on an enabled edge with i_valid && o_ready; operands, opcode and funct fields captured in that edge.
REQ-015 FSM states: IDLE, MUL, DIV, DONE; o_ready = (state == IDLE); o_valid = (state == DONE).
REQ-016 Base ops (opcode 0110011 with funct7 != 0000001, opcode 0010011): ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and immediate forms; IDLE->DONE, o_valid one enabled cycle after acceptance.
REQ-017 SUB/SRA selected by funct7 == 0100000; SRAI selected by i_imm[11:5] == 0100000; shift amount = low log2(XLEN) bits of rs2/imm.
REQ-018 Immediate ops use i_imm sign-extended or truncated to XLEN; SLTIU compares the XLEN-extended immediate unsigned.
REQ-019 Unsupported opcode or funct3 SHALL complete as a base op with result 0.
REQ-020 M ops (opcode 0110011, funct7 0000001): funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU -> state MUL; 100 DIV, 101 DIVU, 110 REM, 111 REMU -> state DIV.
REQ-021 MUL/DIV SHALL iterate one bit per enabled cycle using a 2*XLEN accumulator (shift-add multiply, restoring divide on operand magnitudes); step counter loaded with XLEN, state -> DONE when counter reaches 0; o_valid exactly XLEN+1 enabled cycles after acceptance.
REQ-022 Signed ops: operands converted to magnitudes at acceptance, result sign applied when entering DONE; MULHSU treats rs1 signed, rs2 unsigned; MUL returns low XLEN bits, MULH* high XLEN bits.
REQ-023 Divide by zero: quotient = all ones, remainder = rs1; when DIV_ZERO_FAST=1, IDLE->DONE in one cycle.
REQ-024 Signed overflow (rs1 = most negative, rs2 = -1): DIV returns rs1, REM returns 0, always one cycle.
REQ-025 DONE holds o_rd_data and o_valid stable until an enabled edge with i_ready high, then -> IDLE; no new request accepted in that same edge.
REQ-026 o_busy = (state == MUL || state == DIV).
REQ-027 clk_en low freezes state, counter, accumulator and outputs; i_valid ignored.
REQ-028 i_ready, operand and opcode changes after acceptance SHALL NOT affect an in-flight result.

Reset
REQ-029 rst low SHALL asynchronously force state IDLE, counter 0, accumulator 0, o_rd_data 0, o_valid 0, o_busy 0, o_ready 1 after deassertion (o_ready 0 while rst low).
REQ-030 Reset mid-iteration SHALL discard the operation; no o_valid produced for it.

Verification
REQ-031 ADD rs1=0x7FFFFFFF, rs2=1, i_ready=1 -> o_valid one cycle later, o_rd_data=0x80000000, o_ready high next cycle.
REQ-032 MULH rs1=0x80000000, rs2=0x80000000 -> o_busy 32 cycles, o_valid at cycle 33, o_rd_data=0x40000000; MUL same operands -> 0x00000000.
REQ-033 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 after one cycle; REM same -> 0; DIVU rs1=7, rs2=0 -> 0xFFFFFFFF; REMU -> 7.
REQ-034 REM rs1=-7, rs2=2 -> 0xFFFFFFFF (-1); DIV -> 0xFFFFFFFD (-3); i_ready held low 5 cycles -> o_rd_data and o_valid stable throughout.
REQ-035 clk_en low for 10 cycles mid-DIVU -> completion delayed exactly 10 cycles, result unchanged.
REQ-036 rst asserted at iteration 16 of MULHU -> outputs zero immediately, o_valid never rises for that op, next ADDI accepted normally.
